// File: rtl/uart_fifo_sched.sv
// Round-robin write arbiter for the shared UART FIFO plus the pop/latch/start/wait drain FSM.
// Optional build macro UART_SCHED_PRIO_EN: requester 0 gets absolute write priority.
module uart_fifo_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5,
    parameter int ID_W       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [ID_W-1:0]              grant_id,
    output logic [DATA_BITS-1:0]         fifo_wData,
    output logic                         fifo_wr,
    output logic                         fifo_rd,
    input  logic [DATA_BITS-1:0]         fifo_rData,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [LVL_W-1:0]             level
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [LVL_W:0] DEPTH_W = (LVL_W+1)'(FIFO_DEPTH);

    logic [NUM_REQ-1:0][DATA_BITS-1:0] req_bytes;
    logic [NUM_REQ-1:0]   cand, rot;
    logic [2*NUM_REQ-1:0] dbl;
    logic [ID_W-1:0]      ptr, gnt_idx, ptr_nxt;
    logic                 gnt_vld, room;
    logic [2:0]           state;
    logic                 settle;

    assign req_bytes = req_data;
    // The write already in flight counts against room; the FIFO flags lag too much to use.
    assign room = ({1'b0, level} + {{LVL_W{1'b0}}, fifo_wr}) < DEPTH_W;

    always_comb begin
        // A requester whose ack is on the wire this cycle still shows req; skip it.
        cand = req & ~req_ack;
`ifdef UART_SCHED_PRIO_EN
        cand[0] = 1'b0;
`endif
        dbl     = {cand, cand} >> ptr;
        rot     = dbl[NUM_REQ-1:0];
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
`ifdef UART_SCHED_PRIO_EN
        if (req[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = '0;
        end
`endif
        if (!room) gnt_vld = 1'b0;
        ptr_nxt = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_wr    <= 1'b0;
            fifo_wData <= '0;
            req_ack    <= '0;
            grant_id   <= '0;
            ptr        <= '0;
        end else begin
            fifo_wr <= gnt_vld;
            req_ack <= '0;
            if (gnt_vld) begin
                req_ack[gnt_idx] <= 1'b1;
                fifo_wData       <= req_bytes[gnt_idx];
                grant_id         <= gnt_idx;
`ifdef UART_SCHED_PRIO_EN
                if (gnt_idx != '0) ptr <= ptr_nxt;
`else
                ptr <= ptr_nxt;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else begin
            case ({fifo_wr, fifo_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            settle   <= 1'b0;
            fifo_rd  <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            fifo_rd  <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (level != '0 && !tx_busy) begin
                        state   <= S_POP;
                        fifo_rd <= 1'b1;
                    end
                end
                S_POP: state <= S_LATCH;
                S_LATCH: begin
                    tx_data  <= fifo_rData;
                    tx_start <= 1'b1;
                    state    <= S_START;
                end
                S_START: begin
                    state  <= S_WAIT;
                    settle <= 1'b1;
                end
                S_WAIT: begin
                    // tx_busy only rises a cycle after tx_start, so ignore the first WAIT cycle.
                    settle <= 1'b0;
                    if (!settle && !tx_busy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_sched.sv
// Directed bench for uart_fifo_sched with a queue FIFO model and a fixed-length transmitter model.
module tb_uart_fifo_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic [1:0]  grant_id;
    logic [7:0]  fifo_wData, fifo_rData, tx_data;
    logic        fifo_wr, fifo_rd, tx_start, tx_busy;
    logic [4:0]  level;
    logic        force_busy = 1'b0;
    int          busy_cnt;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  q[$];

    uart_fifo_sched dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
        .grant_id(grant_id), .fifo_wData(fifo_wData), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .fifo_rData(fifo_rData), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .level(level)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            fifo_rData <= '0;
        end else begin
            if (fifo_rd && q.size() > 0) fifo_rData <= q.pop_front();
            if (fifo_wr) q.push_back(fifo_wData);
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy | (busy_cnt != 0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; force_busy = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        n_tests++;
        if ({req_ack, grant_id, fifo_wData, fifo_wr, fifo_rd, tx_data, tx_start, level} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b gid=%0d wd=%h wr=%b rd=%b txd=%h st=%b lvl=%0d, want all 0",
                     req_ack, grant_id, fifo_wData, fifo_wr, fifo_rd, tx_data, tx_start, level);
        end
        reset = 1'b1;
    endtask

    // One byte from requester 0 through the whole write/pop/latch/start path, cycle exact.
    task automatic test_single(input logic [7:0] v);
        req_data = {24'h0, v}; req = 4'b0001;
        step();
        n_tests++;
        if (fifo_wr !== 1'b1 || req_ack !== 4'b0001 || fifo_wData !== v || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_write: wr=%b ack=%b wd=%h gid=%0d, want 1 0001 %h 0", fifo_wr, req_ack, fifo_wData, grant_id, v);
        end
        req = '0;
        step();
        n_tests++;
        if (level !== 5'd1 || req_ack !== 4'b0000) begin
            n_fail++; $display("FAIL single_level1: lvl=%0d ack=%b, want 1 0000", level, req_ack);
        end
        step();
        n_tests++;
        if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL single_pop: rd=%b, want 1", fifo_rd); end
        step();
        n_tests++;
        if (level !== 5'd0 || fifo_rd !== 1'b0) begin
            n_fail++; $display("FAIL single_level0: lvl=%0d rd=%b, want 0 0", level, fifo_rd);
        end
        step();
        n_tests++;
        if (tx_start !== 1'b1 || tx_data !== v) begin
            n_fail++; $display("FAIL single_start: st=%b txd=%h, want 1 %h", tx_start, tx_data, v);
        end
        step();
        n_tests++;
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: st=%b, want 0", tx_start); end
        repeat (10) step();
    endtask

`ifdef UART_SCHED_PRIO_EN
    task automatic test_prio();
        do_reset();
        force_busy = 1'b1; req_data = 32'h44332211; req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL prio_req0 cyc%0d: ack=%b, want 0001", i, req_ack); end
        end
        req = 4'b0100;
        step();
        n_tests++;
        if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL prio_req2: ack=%b, want 0100", req_ack); end
        req = '0;
        step();
    endtask
`else
    // A lone held request must not be granted on consecutive cycles.
    task automatic test_back_to_back();
        force_busy = 1'b1; req_data = 32'h000000C3; req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (req_ack !== ((i % 2 == 0) ? 4'b0001 : 4'b0000)) begin
                n_fail++; $display("FAIL b2b_alt cyc%0d: ack=%b, want %s", i, req_ack, (i % 2 == 0) ? "0001" : "0000");
            end
        end
        req = '0;
    endtask
`endif

    task automatic test_rr_fill();
        logic [7:0] dat [4];
        int n;
        dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        n = 0;
        force_busy = 1'b1; req_data = {dat[3], dat[2], dat[1], dat[0]}; req = 4'b1111;
        for (int i = 0; i < 24; i++) begin
            step();
            if (req_ack != '0) begin
                n_tests++;
                if (req_ack !== 4'(1 << (n % 4)) || fifo_wData !== dat[n % 4]) begin
                    n_fail++;
                    $display("FAIL rr_order ack#%0d: ack=%b wd=%h, want %b %h", n, req_ack, fifo_wData, 4'(1 << (n % 4)), dat[n % 4]);
                end
                n++;
            end
        end
        n_tests++;
        if (n != 16 || level !== 5'd16 || req_ack !== 4'b0000) begin
            n_fail++; $display("FAIL rr_full: acks=%0d lvl=%0d ack=%b, want 16 16 0000", n, level, req_ack);
        end
    endtask

    // Entered with level=16 and req=1111 still held.
    task automatic test_full_pop();
        int n_ack, n_rd;
        n_ack = 0; n_rd = 0;
        force_busy = 1'b0;
        step();
        n_tests++;
        if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL full_pop: rd=%b, want 1", fifo_rd); end
        force_busy = 1'b1;
        step();
        n_tests++;
        if (level !== 5'd15 || req_ack !== 4'b0000) begin
            n_fail++; $display("FAIL full_level15: lvl=%0d ack=%b, want 15 0000", level, req_ack);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (req_ack != '0) n_ack++;
            if (fifo_rd) n_rd++;
        end
        n_tests++;
        if (n_ack != 1 || n_rd != 0 || level !== 5'd16 || tx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL full_refill: acks=%0d rds=%0d lvl=%0d txd=%h, want 1 0 16 11", n_ack, n_rd, level, tx_data);
        end
        req = '0;
    endtask

    task automatic test_simul();
        force_busy = 1'b1; req_data = 32'h44332211; req = 4'b0111;
        repeat (3) step();
        req = '0;
        step();
        n_tests++;
        if (level !== 5'd3) begin n_fail++; $display("FAIL simul_pre: lvl=%0d, want 3", level); end
        req = 4'b0100; force_busy = 1'b0;
        step();
        n_tests++;
        if (fifo_wr !== 1'b1 || fifo_rd !== 1'b1 || req_ack !== 4'b0100 || grant_id !== 2'd2 || level !== 5'd3) begin
            n_fail++;
            $display("FAIL simul_strobes: wr=%b rd=%b ack=%b gid=%0d lvl=%0d, want 1 1 0100 2 3", fifo_wr, fifo_rd, req_ack, grant_id, level);
        end
        req = '0; force_busy = 1'b1;
        step();
        n_tests++;
        if (level !== 5'd3) begin n_fail++; $display("FAIL simul_level: lvl=%0d, want 3", level); end
    endtask

    // Continues from test_simul: the FSM reaches WAIT_TX and stays there while busy is forced.
    task automatic test_reset_wait();
        req = 4'b0011;
        repeat (2) step();
        req = '0;
        repeat (2) step();
        n_tests++;
        if (level !== 5'd5 || tx_data !== 8'h11) begin
            n_fail++; $display("FAIL rstw_pre: lvl=%0d txd=%h, want 5 11", level, tx_data);
        end
        req = 4'b0001; reset = 1'b0;
        #1;
        n_tests++;
        if (level !== 5'd0 || tx_start !== 1'b0 || fifo_wr !== 1'b0 || fifo_rd !== 1'b0 || req_ack !== 4'b0000 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstw_async: lvl=%0d st=%b wr=%b rd=%b ack=%b txd=%h, want 0 0 0 0 0000 00", level, tx_start, fifo_wr, fifo_rd, req_ack, tx_data);
        end
        step();
        n_tests++;
        if (req_ack !== 4'b0000 || fifo_wr !== 1'b0) begin
            n_fail++; $display("FAIL rstw_no_ack: ack=%b wr=%b, want 0000 0", req_ack, fifo_wr);
        end
        req = '0; force_busy = 1'b0; reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
`ifdef UART_SCHED_PRIO_EN
        test_prio();
`else
        test_back_to_back();
`endif
        do_reset();
        test_rr_fill();
        test_full_pop();
        do_reset();
        test_simul();
        test_reset_wait();
        test_single(8'h5C);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_fifo_sched.md
Name: uart_fifo_sched

Overview:
Scheduler that shares the single write port of the UART FIFO between NUM_REQ on-chip requesters (core, timer and peripheral message sources) using round-robin arbitration.
- Drains the FIFO into the UART transmitter through a pop/latch/start/wait state machine.
- Keeps its own occupancy count, because the FIFO's full/empty flags lag by a cycle.
- Sits between the requesters, the FIFO instance and the UART transmitter.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DATA_BITS, 8, byte width, equal to the FIFO data width
FIFO_DEPTH, 16, usable FIFO entries
LVL_W, 5, width of the occupancy counter; must hold FIFO_DEPTH
ID_W, 2, width of grant_id; clog2(NUM_REQ)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester write request; held until ack
req_data  in  NUM_REQ*DATA_BITS  requester i data in bits [i*DATA_BITS +: DATA_BITS]
req_ack  out  NUM_REQ  one-cycle pulse: requester's byte accepted
grant_id  out  ID_W  index of the last granted requester
fifo_wData  out  DATA_BITS  FIFO write data (registered)
fifo_wr  out  1  FIFO write strobe (registered, one cycle per byte)
fifo_rd  out  1  FIFO read strobe (registered, one cycle per byte)
fifo_rData  in  DATA_BITS  FIFO read data; valid the cycle after fifo_rd
tx_data  out  DATA_BITS  byte presented to the UART transmitter
tx_start  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter busy; rises the cycle after tx_start
level  out  LVL_W  entries currently held in the FIFO

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; level=0; round-robin pointer=0; FSM=IDLE. Any in-flight byte is dropped and no ack is issued for it. The FIFO shares the same reset net (inverted to its active-high input).
- level update: +1 on each edge where fifo_wr=1; -1 on each edge where fifo_rd=1; unchanged when both are 1. Saturation is never reached because of the grant rule.
- Write arbitration, evaluated each cycle:
  - Room exists when level + fifo_wr < FIFO_DEPTH.
  - If room exists and any req bit is 1, grant the first requester at or after the pointer, scanning upward with wrap from NUM_REQ-1 to 0.
  - Next edge: fifo_wr=1, fifo_wData=req_data[granted], req_ack[granted]=1, grant_id=granted, pointer=granted+1 (mod NUM_REQ).
  - At most one grant per cycle. A requester is never granted twice in consecutive cycles.
  - A requester still holding req after its ack makes a new request.
  - With no room, no grant, req_ack=0, and the pointer is held.
- Latency: req at cycle t with room -> fifo_wr and req_ack at t+1 -> byte counted in level at t+2.
- Read FSM: IDLE, POP, LATCH, START, WAIT_TX.
  - IDLE -> POP when level>0 and tx_busy=0.
  - POP: fifo_rd=1 for exactly one cycle -> LATCH.
  - LATCH: tx_data <= fifo_rData -> START.
  - START: tx_start=1 for one cycle -> WAIT_TX.
  - WAIT_TX: first cycle unconditional (settle). After that, -> IDLE on the first cycle with tx_busy=0.
  - Minimum byte-to-byte spacing is 5 cycles plus the transmitter busy time.
- Simultaneous fifo_wr and fifo_rd is legal only when level>0. This is guaranteed because POP is entered only with level>0.
- A byte written while level=0 is popped no earlier than the cycle after it is counted.
- tx_data holds its value until the next LATCH.

Optional Feature:
UART_SCHED_PRIO_EN
- Defined: requester 0 has absolute priority whenever req[0]=1 and room exists. The pointer is not advanced by a requester-0 grant. The remaining requesters rotate round-robin as before.
- Undefined: pure round-robin over all requesters, as described in Behaviour.

Test Plan:
- Reset release, req=4'b0001, req_data[7:0]=8'hA5 -> fifo_wr and req_ack[0] one cycle later, level=1 two cycles later; fifo_rd follows, then tx_data=8'hA5 with a tx_start pulse, then level=0.
- req=4'b1111 held continuously with tx_busy forced 1 -> acks in order 0,1,2,3,0,...; exactly 16 writes accepted; then req_ack=0 and level=16 while req stays high.
- From the full state (level=16), release tx_busy -> one pop; level=15 visible the edge after fifo_rd; exactly one new grant follows; level returns to 16.
- Requester 2 issues a write in the same cycle the FSM is in POP with level=3 -> both strobes in one cycle; level remains 3.
- Assert reset while in WAIT_TX with level=5 -> immediately level=0, tx_start=0, fifo_wr=0, FSM=IDLE; no ack for the byte in flight.
- With UART_SCHED_PRIO_EN defined, req=4'b0101 held -> requester 0 acked every cycle, requester 2 never acked until req[0] drops; then requester 2 acked next cycle.
